// File: rtl/ahb_sync_sram_if.sv
// AHB-Lite slave-side bus bundle for the synchronous SRAM controller.
// hready is the system-level HREADY fed back to the slave.
interface ahb_sync_sram_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              hready;
  logic              hready_resp;
  logic              hresp;
  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  modport slave (
    input  hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
    output hready_resp, hresp, hrdata
  );

  modport master (
    output hready, haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
    input  hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sync_sram.sv
// Zero-wait-state AHB-Lite slave in front of a single-port synchronous SRAM.
// A one-entry write buffer absorbs a write data phase that collides with a read address phase.
//
// state  | meaning
// ERR_OK | normal operation, OKAY response
// ERR_1  | first ERROR cycle: hready_resp=0, hresp=1, no address phase accepted
// ERR_2  | second ERROR cycle: hready_resp=1, hresp=1, next address phase accepted
module ahb_sync_sram #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int DEPTH  = 2048,
  localparam int W_SRAM_ADDR = $clog2(DEPTH),
  localparam int W_MASK      = W_DATA / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ahb_sync_sram_if.slave         ahbls,
  output logic [W_SRAM_ADDR-1:0] sram_addr,
  output logic                   sram_cs,
  output logic                   sram_we,
  output logic [W_MASK-1:0]      sram_wmask,
  output logic [W_DATA-1:0]      sram_wdata,
  input  logic [W_DATA-1:0]      sram_rdata
);

  typedef enum logic [1:0] {ERR_OK, ERR_1, ERR_2} err_state_t;

  err_state_t err_q, err_next;

  logic                   dph_read, dph_write;
  logic [W_SRAM_ADDR-1:0] dph_addr;
  logic [W_MASK-1:0]      dph_mask;

  logic                   wbuf_valid;
  logic [W_SRAM_ADDR-1:0] wbuf_addr;
  logic [W_MASK-1:0]      wbuf_mask;
  logic [W_DATA-1:0]      wbuf_data;

  logic                   aphase, bad_access, accept_ok, rd_accept, wr_accept;
  logic                   wbuf_load, wbuf_commit, wbuf_hit;
  logic [W_MASK-1:0]      aph_mask;
  logic [W_SRAM_ADDR-1:0] aph_addr;

  // No address phase is taken during ERR_1, regardless of system hready.
  assign aphase    = rst_n && ahbls.hready && ahbls.htrans[1] && (err_q != ERR_1);
  assign accept_ok = aphase && !bad_access;
  assign rd_accept = accept_ok && !ahbls.hwrite;
  assign wr_accept = accept_ok && ahbls.hwrite;
  assign aph_addr  = ahbls.haddr[2 +: W_SRAM_ADDR];

  assign wbuf_load   = dph_write && rd_accept;
  assign wbuf_commit = wbuf_valid && !rd_accept && !dph_write;
  assign wbuf_hit    = wbuf_valid && (wbuf_addr == dph_addr);

  always_comb begin
    bad_access = 1'b0;
    aph_mask   = '1;
    case (ahbls.hsize)
      3'd0: aph_mask = W_MASK'(4'b0001 << ahbls.haddr[1:0]);
      3'd1: begin
        aph_mask   = W_MASK'(4'b0011 << ahbls.haddr[1:0]);
        bad_access = ahbls.haddr[0];
      end
      3'd2: bad_access = |ahbls.haddr[1:0];
      default: bad_access = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= ERR_OK;
    end else begin
      err_q <= err_next;
    end
  end

  always_comb begin
    err_next          = err_q;
    ahbls.hready_resp = 1'b1;
    ahbls.hresp       = 1'b0;
    case (err_q)
      ERR_OK: if (aphase && bad_access) err_next = ERR_1;
      ERR_1: begin
        ahbls.hready_resp = 1'b0;
        ahbls.hresp       = 1'b1;
        err_next          = ERR_2;
      end
      ERR_2: begin
        ahbls.hresp = 1'b1;
        err_next    = (aphase && bad_access) ? ERR_1 : ERR_OK;
      end
      default: err_next = ERR_OK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dph_read   <= 1'b0;
      dph_write  <= 1'b0;
      dph_addr   <= '0;
      dph_mask   <= '0;
      wbuf_valid <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_mask  <= '0;
      wbuf_data  <= '0;
    end else begin
      dph_read  <= rd_accept;
      dph_write <= wr_accept;
      if (accept_ok) begin
        dph_addr <= aph_addr;
        dph_mask <= aph_mask;
      end
      if (wbuf_load) begin
        wbuf_valid <= 1'b1;
        wbuf_addr  <= dph_addr;
        wbuf_mask  <= dph_mask;
        wbuf_data  <= ahbls.hwdata;
      end else if (wbuf_commit) begin
        wbuf_valid <= 1'b0;
      end
    end
  end

  // Port priority: read address phase, then direct write, then buffer drain.
  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = dph_addr;
    sram_wmask = dph_mask;
    sram_wdata = ahbls.hwdata;
    if (rst_n) begin
      if (rd_accept) begin
        sram_cs   = 1'b1;
        sram_addr = aph_addr;
      end else if (dph_write) begin
        sram_cs = 1'b1;
        sram_we = 1'b1;
      end else if (wbuf_valid) begin
        sram_cs    = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = wbuf_addr;
        sram_wmask = wbuf_mask;
        sram_wdata = wbuf_data;
      end
    end
  end

  always_comb begin
    ahbls.hrdata = '0;
    if (dph_read) begin
      for (int i = 0; i < W_MASK; i++) begin
        ahbls.hrdata[8*i +: 8] = (wbuf_hit && wbuf_mask[i]) ? wbuf_data[8*i +: 8]
                                                            : sram_rdata[8*i +: 8];
      end
    end
  end

  ap_wbuf_empty_at_wdph: assert property (@(posedge clk) disable iff (!rst_n)
    dph_write |-> !wbuf_valid);
  ap_no_load_when_valid: assert property (@(posedge clk) disable iff (!rst_n)
    !(wbuf_valid && wbuf_load));

endmodule
